// File: rtl/gtp_drp_pkg.sv
// Shared types for the GTP DRP master: DRP bus widths, command opcodes,
// controller state encoding and the read-modify-write merge.
package gtp_drp_pkg;

   localparam int DRP_AW = 8;
   localparam int DRP_DW = 16;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_RMW   = 2'b10,
      OP_RSVD  = 2'b11
   } drp_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_WAIT = 3'd4,
      ST_RESP    = 3'd5,
      ST_GAP     = 3'd6
   } drp_state_e;

   // Mask bit 1 takes the new write data, mask bit 0 keeps the device value.
   function automatic logic [DRP_DW-1:0] rmw_merge(input logic [DRP_DW-1:0] rd,
                                                    input logic [DRP_DW-1:0] wd,
                                                    input logic [DRP_DW-1:0] mask);
      return (rd & ~mask) | (wd & mask);
   endfunction

endpackage

// File: rtl/gtp_drp_master.sv
// Single-outstanding DRP master: read, write and read-modify-write commands
// with a DRPRDY timeout and a forced idle gap after every completion.
module gtp_drp_master
   import gtp_drp_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned GAP_CYCLES     = 1
) (
   input  logic              DRPCLK,
   input  logic              DRPRSTN,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [1:0]        CMD_OP,
   input  logic [DRP_AW-1:0] CMD_ADDR,
   input  logic [DRP_DW-1:0] CMD_WDATA,
   input  logic [DRP_DW-1:0] CMD_WMASK,
   output logic              RSP_VALID,
   output logic [DRP_DW-1:0] RSP_RDATA,
   output logic              RSP_ERR,
   output logic              DRPEN,
   output logic              DRPWE,
   output logic [DRP_AW-1:0] DRPADDR,
   output logic [DRP_DW-1:0] DRPDI,
   input  logic              DRPRDY,
   input  logic [DRP_DW-1:0] DRPDO,
   output logic              BUSY
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES);
   localparam logic [2:0] GAP_LAST     = 3'(GAP_CYCLES - 1);

   drp_state_e        state_q, state_d;
   drp_op_e           op_q, op_d;
   logic [DRP_AW-1:0] addr_q, addr_d;
   logic [DRP_DW-1:0] wdata_q, wdata_d;
   logic [DRP_DW-1:0] mask_q, mask_d;
   logic [DRP_DW-1:0] di_q, di_d;
   logic [DRP_DW-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              wr_pend_q, wr_pend_d;
   logic [7:0]        wait_q, wait_d;
   logic [2:0]        gap_q, gap_d;
   logic              ready_q;
   logic              accept;
   logic [7:0]        wait_inc;
   logic              timeout;

   // ready_q keeps CMD_READY low while reset is held and for no longer.
   assign CMD_READY = ready_q && (state_q == ST_IDLE);
   assign accept    = CMD_VALID && CMD_READY;
   assign BUSY      = (state_q != ST_IDLE);
   assign DRPEN     = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
   assign DRPWE     = (state_q == ST_WR_REQ);
   assign DRPADDR   = addr_q;
   assign DRPDI     = di_q;
   assign RSP_VALID = (state_q == ST_RESP);
   assign RSP_RDATA = RSP_VALID ? rdata_q : '0;
   assign RSP_ERR   = RSP_VALID && err_q;

   // A DRPRDY in the same cycle the count reaches the limit wins over timeout.
   assign wait_inc = wait_q + 8'd1;
   assign timeout  = (wait_inc == TIMEOUT_LAST);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      di_d      = di_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      wr_pend_d = wr_pend_q;
      wait_d    = wait_q;
      gap_d     = gap_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d      = drp_op_e'(CMD_OP);
               addr_d    = CMD_ADDR;
               wdata_d   = CMD_WDATA;
               mask_d    = CMD_WMASK;
               di_d      = (drp_op_e'(CMD_OP) == OP_WRITE) ? CMD_WDATA : '0;
               rdata_d   = '0;
               err_d     = 1'b0;
               wr_pend_d = 1'b0;
               unique case (drp_op_e'(CMD_OP))
                  OP_READ, OP_RMW: state_d = ST_RD_REQ;
                  OP_WRITE:        state_d = ST_WR_REQ;
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_RESP;
                  end
               endcase
            end
         end
         ST_RD_REQ: begin
            wait_d  = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            wait_d = wait_inc;
            if (DRPRDY) begin
               rdata_d = DRPDO;
               if (op_q == OP_RMW) begin
                  di_d      = rmw_merge(DRPDO, wdata_q, mask_q);
                  wr_pend_d = 1'b1;
                  gap_d     = '0;
                  state_d   = ST_GAP;
               end else begin
                  state_d = ST_RESP;
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_WR_REQ: begin
            wait_d    = '0;
            wr_pend_d = 1'b0;
            state_d   = ST_WR_WAIT;
         end
         ST_WR_WAIT: begin
            wait_d = wait_inc;
            if (DRPRDY) begin
               state_d = ST_RESP;
            end else if (timeout) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            gap_d   = '0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = wr_pend_q ? ST_WR_REQ : ST_IDLE;
            end else begin
               gap_d = gap_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge DRPCLK or negedge DRPRSTN) begin
      if (!DRPRSTN) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_READ;
         addr_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         di_q      <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         wr_pend_q <= 1'b0;
         wait_q    <= '0;
         gap_q     <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mask_q    <= mask_d;
         di_q      <= di_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         wr_pend_q <= wr_pend_d;
         wait_q    <= wait_d;
         gap_q     <= gap_d;
         ready_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gtp_drp_master.sv
// Bench for gtp_drp_master: DRP device model with programmable DRPRDY latency,
// directed vector table, hand-written corner sequences and random commands.
module tb_gtp_drp_master;
   import gtp_drp_pkg::*;

   localparam int TMO   = 8;
   localparam int GAP   = 2;
   localparam int NEVER = 0;

   logic        DRPCLK = 1'b0;
   logic        DRPRSTN = 1'b0;
   logic        CMD_VALID = 1'b0;
   logic        CMD_READY;
   logic [1:0]  CMD_OP = 2'b00;
   logic [7:0]  CMD_ADDR = '0;
   logic [15:0] CMD_WDATA = '0;
   logic [15:0] CMD_WMASK = '0;
   logic        RSP_VALID;
   logic [15:0] RSP_RDATA;
   logic        RSP_ERR;
   logic        DRPEN, DRPWE;
   logic [7:0]  DRPADDR;
   logic [15:0] DRPDI;
   logic        DRPRDY;
   logic [15:0] DRPDO;
   logic        BUSY;

   gtp_drp_master #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
      .DRPCLK(DRPCLK), .DRPRSTN(DRPRSTN),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WMASK(CMD_WMASK),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .DRPEN(DRPEN), .DRPWE(DRPWE), .DRPADDR(DRPADDR), .DRPDI(DRPDI),
      .DRPRDY(DRPRDY), .DRPDO(DRPDO), .BUSY(BUSY)
   );

   always #5 DRPCLK = ~DRPCLK;

   int cyc = 0;
   always @(posedge DRPCLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- DRP device model ----------------
   logic [15:0] dev_mem [256];
   logic [15:0] ref_mem [256];
   int          cur_lat = 1;
   int          pend = 0;
   logic [15:0] pend_data;
   logic [7:0]  pend_addr;
   int          unstable = 0;
   bit          stray = 1'b0;
   int          en_cyc [$];
   logic        en_we [$];

   initial begin : responder
      DRPRDY = 1'b0;
      DRPDO  = '0;
      forever begin
         @(negedge DRPCLK);
         DRPRDY = 1'b0;
         DRPDO  = '0;
         if (!DRPRSTN) begin
            pend = 0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  DRPRDY = 1'b1;
                  DRPDO  = pend_data;
                  if (DRPADDR !== pend_addr) unstable++;
               end
            end
            if (DRPEN) begin
               en_cyc.push_back(cyc);
               en_we.push_back(DRPWE);
               pend_addr = DRPADDR;
               pend_data = dev_mem[DRPADDR];
               if (DRPWE) dev_mem[DRPADDR] = DRPDI;
               if (cur_lat != NEVER) pend = cur_lat;
            end
            if (stray) begin
               DRPRDY = 1'b1;
               DRPDO  = 16'hDEAD;
            end
         end
      end
   end

   // ---------------- transaction driver and reference model ----------------
   typedef struct {
      int          rsp_off;
      logic [15:0] rdata;
      logic        err;
      int          n_en;
      int          en1;
      int          en2;
      logic        we1;
      logic        we2;
      int          ready_off;
      int          extra_rsp;
      int          unstable;
      bit          timeout;
   } obs_t;

   typedef struct {
      int          rsp_off;
      logic [15:0] rdata;
      logic        err;
      int          n_en;
      int          en2;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [15:0] wd;
      logic [15:0] mk;
      int          lat;
      int          rsp_off;
      logic [15:0] rdata;
      logic        err;
      int          n_en;
      int          en2;
   } vec_t;

   // Offsets are in cycles counted from the accept cycle.
   task automatic model(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd,
                        input logic [15:0] mk, input int lat, output exp_t e);
      bit          ok;
      logic [15:0] old;
      ok = (lat >= 1) && (lat <= TMO);
      e  = '{default: 0};
      case (op)
         OP_READ: begin
            e.n_en    = 1;
            e.rsp_off = ok ? lat + 2 : TMO + 2;
            e.rdata   = ok ? ref_mem[addr] : 16'h0;
            e.err     = !ok;
         end
         OP_WRITE: begin
            e.n_en    = 1;
            ref_mem[addr] = wd;
            e.rsp_off = ok ? lat + 2 : TMO + 2;
            e.err     = !ok;
         end
         OP_RMW: begin
            if (!ok) begin
               e.n_en    = 1;
               e.rsp_off = TMO + 2;
               e.err     = 1'b1;
            end else begin
               old           = ref_mem[addr];
               ref_mem[addr] = (old & ~mk) | (wd & mk);
               e.n_en        = 2;
               e.en2         = lat + GAP + 2;
               e.rsp_off     = 2 * lat + GAP + 3;
               e.rdata       = old;
            end
         end
         default: begin
            e.rsp_off = 1;
            e.err     = 1'b1;
         end
      endcase
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd,
                         input logic [15:0] mk, input int lat, output obs_t o);
      int n0;
      bit got;
      o = '{default: 0};
      cur_lat = lat;
      en_cyc.delete();
      en_we.delete();
      unstable = 0;
      for (int i = 0; i < 50 && !CMD_READY; i++) @(negedge DRPCLK);
      if (!CMD_READY) begin
         o.timeout = 1'b1;
         return;
      end
      n0 = cyc;
      CMD_VALID = 1'b1;
      CMD_OP    = op;
      CMD_ADDR  = addr;
      CMD_WDATA = wd;
      CMD_WMASK = mk;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge DRPCLK);
         CMD_VALID = 1'b0;
         if (RSP_VALID) begin
            if (got) o.extra_rsp++;
            else begin
               got       = 1'b1;
               o.rsp_off = cyc - n0;
               o.rdata   = RSP_RDATA;
               o.err     = RSP_ERR;
            end
         end
         if (got && CMD_READY) begin
            o.ready_off = cyc - n0 - o.rsp_off;
            break;
         end
      end
      if (!got || !CMD_READY) o.timeout = 1'b1;
      o.n_en = en_cyc.size();
      if (o.n_en > 0) begin
         o.en1 = en_cyc[0] - n0;
         o.we1 = en_we[0];
      end
      if (o.n_en > 1) begin
         o.en2 = en_cyc[1] - n0;
         o.we2 = en_we[1];
      end
      o.unstable = unstable;
   endtask

   task automatic compare(input string tag, input logic [1:0] op, input logic [7:0] addr,
                          input obs_t o, input exp_t e);
      check($sformatf("%s.completed", tag), 32'(o.timeout), 0);
      check($sformatf("%s.rsp_cycle", tag), o.rsp_off, e.rsp_off);
      check($sformatf("%s.rdata", tag), 32'(o.rdata), 32'(e.rdata));
      check($sformatf("%s.err", tag), 32'(o.err), 32'(e.err));
      check($sformatf("%s.drpen_count", tag), o.n_en, e.n_en);
      if (e.n_en > 0) begin
         check($sformatf("%s.drpen_cycle", tag), o.en1, 1);
         check($sformatf("%s.drpwe_first", tag), 32'(o.we1), 32'(op == OP_WRITE));
      end
      if (e.n_en == 2) begin
         check($sformatf("%s.rmw_write_cycle", tag), o.en2, e.en2);
         check($sformatf("%s.rmw_write_we", tag), 32'(o.we2), 1);
      end
      check($sformatf("%s.ready_after_gap", tag), o.ready_off, GAP + 1);
      check($sformatf("%s.single_rsp", tag), o.extra_rsp, 0);
      check($sformatf("%s.addr_stable", tag), o.unstable, 0);
      check($sformatf("%s.device_mem", tag), 32'(dev_mem[addr]), 32'(ref_mem[addr]));
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      vec_t vecs [10];
      obs_t o;
      exp_t e;
      exp_t dummy;
      int   n0;
      int   first_en;
      bit   got;
      bit   bad;
      logic [1:0] rop;
      logic [7:0] raddr;
      int   rlat;

      for (int i = 0; i < 256; i++) begin
         dev_mem[i] = '0;
         ref_mem[i] = '0;
      end
      dev_mem[8'h00] = 16'h0004;  ref_mem[8'h00] = 16'h0004;
      dev_mem[8'h10] = 16'h1234;  ref_mem[8'h10] = 16'h1234;

      // Reset state while DRPRSTN is held low
      #1;
      check("reset.cmd_ready", 32'(CMD_READY), 0);
      check("reset.busy", 32'(BUSY), 0);
      check("reset.drpen", 32'(DRPEN), 0);
      check("reset.rsp_valid", 32'(RSP_VALID), 0);
      check("reset.drpaddr", 32'(DRPADDR), 0);
      repeat (2) @(negedge DRPCLK);
      DRPRSTN = 1'b1;
      @(negedge DRPCLK);
      check("reset.ready_after_release", 32'(CMD_READY), 1);

      //          op        addr   wdata     mask      lat   rsp rdata    err n_en en2
      vecs[0] = '{OP_READ,  8'h00, 16'h0000, 16'h0000, 1,     3, 16'h0004, 0, 1, 0};
      vecs[1] = '{OP_WRITE, 8'h05, 16'hA5A5, 16'h0000, 1,     3, 16'h0000, 0, 1, 0};
      vecs[2] = '{OP_RMW,   8'h10, 16'hABCD, 16'h00FF, 1,     7, 16'h1234, 0, 2, 5};
      vecs[3] = '{OP_READ,  8'h22, 16'h0000, 16'h0000, NEVER, 10, 16'h0000, 1, 1, 0};
      vecs[4] = '{OP_RSVD,  8'h33, 16'h0000, 16'h0000, 1,     1, 16'h0000, 1, 0, 0};
      vecs[5] = '{OP_READ,  8'h05, 16'h0000, 16'h0000, 8,     10, 16'hA5A5, 0, 1, 0};
      vecs[6] = '{OP_READ,  8'h05, 16'h0000, 16'h0000, 9,     10, 16'h0000, 1, 1, 0};
      vecs[7] = '{OP_WRITE, 8'h40, 16'hBEEF, 16'h0000, NEVER, 10, 16'h0000, 1, 1, 0};
      vecs[8] = '{OP_RMW,   8'h10, 16'hFFFF, 16'hFFFF, NEVER, 10, 16'h0000, 1, 1, 0};
      vecs[9] = '{OP_RMW,   8'h10, 16'h0000, 16'hF0F0, 2,     9, 16'h12CD, 0, 2, 6};

      for (int i = 0; i < 10; i++) begin
         model(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].mk, vecs[i].lat, dummy);
         e = '{vecs[i].rsp_off, vecs[i].rdata, vecs[i].err, vecs[i].n_en, vecs[i].en2};
         do_cmd(vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].mk, vecs[i].lat, o);
         compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, o, e);
      end
      check("vec.rmw_merged_value", 32'(dev_mem[8'h10]), 32'h020D);

      // Reset asserted while the read waits for DRPRDY
      cur_lat = NEVER;
      n0 = cyc;
      CMD_VALID = 1'b1;  CMD_OP = OP_READ;  CMD_ADDR = 8'h05;
      @(negedge DRPCLK);
      CMD_VALID = 1'b0;
      repeat (2) @(negedge DRPCLK);
      check("midrst.busy_before", 32'(BUSY), 1);
      DRPRSTN = 1'b0;
      #1;
      check("midrst.drpen", 32'(DRPEN), 0);
      check("midrst.drpwe", 32'(DRPWE), 0);
      check("midrst.drpaddr", 32'(DRPADDR), 0);
      check("midrst.drpdi", 32'(DRPDI), 0);
      check("midrst.rsp_valid", 32'(RSP_VALID), 0);
      check("midrst.rsp_rdata", 32'(RSP_RDATA), 0);
      check("midrst.rsp_err", 32'(RSP_ERR), 0);
      check("midrst.busy", 32'(BUSY), 0);
      check("midrst.cmd_ready", 32'(CMD_READY), 0);
      @(negedge DRPCLK);
      DRPRSTN = 1'b1;
      @(negedge DRPCLK);
      check("midrst.ready_after_release", 32'(CMD_READY), 1);
      model(OP_READ, 8'h05, 16'h0, 16'h0, 2, e);
      do_cmd(OP_READ, 8'h05, 16'h0, 16'h0, 2, o);
      compare("midrst.reread", OP_READ, 8'h05, o, e);

      // Reserved opcode followed by a second command held on CMD_VALID
      cur_lat = 1;
      n0 = cyc;
      CMD_VALID = 1'b1;  CMD_OP = OP_RSVD;  CMD_ADDR = 8'h00;
      @(negedge DRPCLK);
      CMD_OP = OP_READ;
      check("b2b.rsvd_rsp_valid", 32'(RSP_VALID), 1);
      check("b2b.rsvd_rsp_err", 32'(RSP_ERR), 1);
      check("b2b.no_drpen_rsvd", 32'(DRPEN), 0);
      first_en = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge DRPCLK);
         if (DRPEN) begin
            first_en = cyc - n0;
            break;
         end
      end
      CMD_VALID = 1'b0;
      check("b2b.second_drpen_cycle", first_en, GAP + 3);
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge DRPCLK);
         if (RSP_VALID) begin
            got = 1'b1;
            check("b2b.second_rsp_cycle", cyc - n0, GAP + 5);
            check("b2b.second_rdata", 32'(RSP_RDATA), 32'(ref_mem[8'h00]));
            break;
         end
      end
      check("b2b.second_rsp_seen", 32'(got), 1);
      for (int i = 0; i < 10 && !CMD_READY; i++) @(negedge DRPCLK);

      // DRPRDY while idle is ignored
      bad = 1'b0;
      stray = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge DRPCLK);
         bad |= RSP_VALID | BUSY | DRPEN;
      end
      stray = 1'b0;
      @(negedge DRPCLK);
      check("stray_rdy.ignored", 32'(bad), 0);

      // Random commands against the reference model
      for (int i = 0; i < 30; i++) begin
         rop   = 2'($urandom_range(0, 3));
         raddr = 8'($urandom_range(0, 7));
         rlat  = $urandom_range(0, 9);
         CMD_WDATA = 16'($urandom);
         CMD_WMASK = 16'($urandom);
         model(rop, raddr, CMD_WDATA, CMD_WMASK, rlat, e);
         do_cmd(rop, raddr, CMD_WDATA, CMD_WMASK, rlat, o);
         compare($sformatf("rnd%0d", i), rop, raddr, o, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
